// File: rtl/uart_frame_rx.sv
// uart_frame_rx: pops bytes from a uart receive FIFO and parses frames of the
//    form SOF, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and the payload.
//    A checked frame is held in a local buffer until the consumer acknowledges it.
//    No bytes are popped while a frame is held, so the uart FIFO absorbs the backlog.
// Latency: one byte per cycle while rx_empty stays low. frm_valid rises in the
//    cycle after the pop of a correct CHK byte.
// Ports:
//    clk, rst (sync, active low)       clock and reset
//    rx_empty, r_data, rd_uart         uart FIFO head and pop strobe
//    frm_valid, frm_len                frame held, and its payload length
//    frm_addr, frm_byte, frm_ack       payload readout and release of the frame
//    chk_err, len_err                  one-cycle error pulses
//    drop_cnt                          saturating count of non-SOF bytes dropped in IDLE
// Option: define UART_FRAME_TIMEOUT_EN to abandon a partial frame after
//    TIMEOUT_CYC cycles without a byte. Without it a partial frame waits forever.
module uart_frame_rx #(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SOF         = 8'hA5,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   output logic       frm_valid,
   output logic [4:0] frm_len,
   input  logic [4:0] frm_addr,
   output logic [7:0] frm_byte,
   input  logic       frm_ack,
   output logic       chk_err,
   output logic       len_err,
   output logic [7:0] drop_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_HOLD} state_t;

   state_t     state, state_nxt;
   logic [4:0] len_q;
   logic [4:0] idx;
   logic [7:0] chk_q;
   logic [7:0] buffer [0:31];
   logic       len_ok;
   logic       last_byte;
   logic       tmo;

   assign len_ok    = (r_data != 8'h00) && (r_data <= 8'(MAX_LEN));
   assign last_byte = (idx == len_q - 5'd1);
   assign frm_len   = len_q;

`ifdef UART_FRAME_TIMEOUT_EN
   logic [31:0] idle_cnt;

   // Counts cycles without a pop while a frame is in progress.
   always_ff @(posedge clk) begin
      if (!rst || rd_uart || state == S_IDLE || state == S_HOLD)
         idle_cnt <= 32'd0;
      else
         idle_cnt <= idle_cnt + 32'd1;
   end

   // Fires on the TIMEOUT_CYC-th consecutive empty cycle of a partial frame.
   assign tmo = (state == S_LEN || state == S_DATA || state == S_CHK) &&
                !rd_uart && (idle_cnt == 32'(TIMEOUT_CYC - 1));
`else
   // Timeout disabled; the parameter only keeps the interface uniform.
   assign tmo = (TIMEOUT_CYC < 0);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (rd_uart && r_data == SOF) state_nxt = S_LEN;
         S_LEN: begin
            if (rd_uart)  state_nxt = len_ok ? S_DATA : S_IDLE;
            else if (tmo) state_nxt = S_IDLE;
         end
         S_DATA: begin
            if (rd_uart && last_byte) state_nxt = S_CHK;
            else if (tmo)             state_nxt = S_IDLE;
         end
         S_CHK: begin
            if (rd_uart)  state_nxt = (r_data == chk_q) ? S_HOLD : S_IDLE;
            else if (tmo) state_nxt = S_IDLE;
         end
         S_HOLD: if (frm_ack) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs: pop whenever a byte is available and no frame is held.
   // Gating with rst keeps the FIFO untouched while reset is asserted.
   always_comb begin
      rd_uart   = rst && !rx_empty && (state != S_HOLD);
      frm_valid = (state == S_HOLD);
   end

   // Datapath: length, index, running checksum, error pulses, drop counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         len_q    <= 5'd0;
         idx      <= 5'd0;
         chk_q    <= 8'h00;
         chk_err  <= 1'b0;
         len_err  <= 1'b0;
         drop_cnt <= 8'h00;
      end else begin
         chk_err <= 1'b0;
         len_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rd_uart && r_data != SOF && drop_cnt != 8'hFF)
                  drop_cnt <= drop_cnt + 8'd1;
            end
            S_LEN: begin
               if (rd_uart) begin
                  if (len_ok) begin
                     len_q <= r_data[4:0];
                     chk_q <= r_data;
                     idx   <= 5'd0;
                  end else begin
                     len_err <= 1'b1;
                  end
               end else if (tmo) begin
                  len_err <= 1'b1;
               end
            end
            S_DATA: begin
               if (rd_uart) begin
                  chk_q <= chk_q ^ r_data;
                  idx   <= idx + 5'd1;
               end else if (tmo) begin
                  chk_err <= 1'b1;
               end
            end
            S_CHK: begin
               if (rd_uart) begin
                  if (r_data != chk_q) chk_err <= 1'b1;
               end else if (tmo) begin
                  chk_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Payload buffer needs no reset; only entries below len_q are ever read.
   always_ff @(posedge clk) begin
      if (state == S_DATA && rd_uart) buffer[idx] <= r_data;
   end

   always_comb begin
      frm_byte = 8'h00;
      if (frm_addr < frm_len) frm_byte = buffer[frm_addr];
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx. A behavioural uart FIFO (array with
// head/tail pointers) feeds the DUT; frames are checked against hand-computed
// values. Checksums follow CHK = XOR of LEN and all payload bytes.
module tb_uart_frame_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_empty = 1'b1;
   logic [7:0] r_data = 8'h00;
   logic       rd_uart;
   logic       frm_valid;
   logic [4:0] frm_len;
   logic [4:0] frm_addr = 5'd0;
   logic [7:0] frm_byte;
   logic       frm_ack = 1'b0;
   logic       chk_err;
   logic       len_err;
   logic [7:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   // FIFO model: tail written by the stimulus, head by the monitor
   logic [7:0] mem [0:1023];
   int head = 0;
   int tail = 0;

   // Monitor state, written only by the monitor process
   int cyc = 0;
   int pop_total = 0;
   int last_pop_cyc = 0;
   int pop_cycs[$];
   int chk_cnt = 0;
   int len_cnt = 0;

   int fv_cyc = 0;

   always #5 clk = ~clk;

   uart_frame_rx #(.MAX_LEN(16), .SOF(8'hA5), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data),
      .rd_uart(rd_uart), .frm_valid(frm_valid), .frm_len(frm_len),
      .frm_addr(frm_addr), .frm_byte(frm_byte), .frm_ack(frm_ack),
      .chk_err(chk_err), .len_err(len_err), .drop_cnt(drop_cnt)
   );

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rd_uart) begin
         if (head != tail) head = head + 1;
         pop_total = pop_total + 1;
         last_pop_cyc = cyc;
         pop_cycs.push_back(cyc);
      end
      if (chk_err) chk_cnt = chk_cnt + 1;
      if (len_err) len_cnt = len_cnt + 1;
   end

   always @(negedge clk) begin
      rx_empty = (head == tail);
      r_data   = (head != tail) ? mem[head] : 8'h00;
   end

   task automatic push(input logic [7:0] b);
      mem[tail] = b;
      tail = tail + 1;
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (head == tail) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (frm_valid) begin ok = 1'b1; fv_cyc = cyc; break; end
      end
   endtask

   task automatic do_ack();
      frm_ack = 1'b1;
      @(negedge clk);
      frm_ack = 1'b0;
   endtask

   task automatic read_byte(input logic [4:0] a);
      frm_addr = a;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (rd_uart !== 1'b0)   begin errors++; $display("FAIL rst_rd_uart got %b want 0", rd_uart); end
      checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL rst_frm_valid got %b want 0", frm_valid); end
      checks++; if (frm_len !== 5'd0)   begin errors++; $display("FAIL rst_frm_len got %0d want 0", frm_len); end
      checks++; if (chk_err !== 1'b0)   begin errors++; $display("FAIL rst_chk_err got %b want 0", chk_err); end
      checks++; if (len_err !== 1'b0)   begin errors++; $display("FAIL rst_len_err got %b want 0", len_err); end
      checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_drop_cnt got %h want 00", drop_cnt); end
      checks++; if (frm_byte !== 8'h00) begin errors++; $display("FAIL rst_frm_byte got %h want 00", frm_byte); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_good_frame();
      bit ok;
      logic [7:0] bytes [6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      logic [4:0] adr   [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
      logic [7:0] expb  [5] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
      foreach (bytes[i]) push(bytes[i]);
      wait_valid(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", ok); end
      checks++; if (fv_cyc != last_pop_cyc) begin errors++; $display("FAIL good_latency got %0d want %0d", fv_cyc, last_pop_cyc); end
      checks++; if (frm_len !== 5'd3) begin errors++; $display("FAIL good_len got %0d want 3", frm_len); end
      foreach (adr[i]) begin
         read_byte(adr[i]);
         checks++; if (frm_byte !== expb[i]) begin errors++; $display("FAIL good_byte[%0d] got %h want %h", adr[i], frm_byte, expb[i]); end
      end
      checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL good_drop got %h want 00", drop_cnt); end
      @(negedge clk);
      do_ack();
      checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL good_ack got %b want 0", frm_valid); end
   endtask

   task automatic test_chk_err();
      bit ok;
      int cb = chk_cnt;
      int lb = len_cnt;
      logic [7:0] bytes [5] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
      foreach (bytes[i]) push(bytes[i]);
      wait_drain(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL chk_drain got %b want 1", ok); end
      checks++; if (chk_cnt - cb != 1) begin errors++; $display("FAIL chk_pulses got %0d want 1", chk_cnt - cb); end
      checks++; if (len_cnt - lb != 0) begin errors++; $display("FAIL chk_len_pulses got %0d want 0", len_cnt - lb); end
      checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL chk_valid got %b want 0", frm_valid); end
   endtask

   task automatic test_len_err_drop();
      bit ok;
      int lb = len_cnt;
      int cb = chk_cnt;
      push(8'h00); push(8'hA5); push(8'h00);
      wait_drain(ok);
      checks++; if (len_cnt - lb != 1) begin errors++; $display("FAIL len_zero_pulses got %0d want 1", len_cnt - lb); end
      checks++; if (drop_cnt !== 8'h01) begin errors++; $display("FAIL drop_one got %h want 01", drop_cnt); end
      for (int i = 0; i < 300; i++) push(8'h5A);
      wait_drain(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drop_drain got %b want 1", ok); end
      checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL drop_sat got %h want ff", drop_cnt); end
      checks++; if (len_cnt - lb != 1) begin errors++; $display("FAIL drop_len_pulses got %0d want 1", len_cnt - lb); end
      // Length one above MAX_LEN is illegal
      push(8'hA5); push(8'h11);
      wait_drain(ok);
      checks++; if (len_cnt - lb != 2) begin errors++; $display("FAIL len_big_pulses got %0d want 2", len_cnt - lb); end
      checks++; if (chk_cnt - cb != 0) begin errors++; $display("FAIL len_chk_pulses got %0d want 0", chk_cnt - cb); end
   endtask

   task automatic test_hold_backpressure();
      bit ok;
      int pb;
      int n = 0;
      logic [7:0] bytes [9] = '{8'hA5, 8'h01, 8'h42, 8'h43, 8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
      foreach (bytes[i]) push(bytes[i]);
      wait_valid(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hold_valid got %b want 1", ok); end
      pb = pop_total;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (rd_uart) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL hold_rd_uart got %0d want 0", n); end
      checks++; if (pop_total != pb) begin errors++; $display("FAIL hold_pops got %0d want %0d", pop_total, pb); end
      checks++; if (tail - head != 5) begin errors++; $display("FAIL hold_fifo_level got %0d want 5", tail - head); end
      read_byte(5'd0);
      checks++; if (frm_byte !== 8'h42) begin errors++; $display("FAIL hold_byte0 got %h want 42", frm_byte); end
      @(negedge clk);
      do_ack();
      wait_valid(ok);
      checks++; if (frm_len !== 5'd2) begin errors++; $display("FAIL hold_next_len got %0d want 2", frm_len); end
      read_byte(5'd1);
      checks++; if (frm_byte !== 8'h02) begin errors++; $display("FAIL hold_next_byte1 got %h want 02", frm_byte); end
      @(negedge clk);
      do_ack();
   endtask

   task automatic test_ack_outside_hold();
      bit ok;
      push(8'hA5); push(8'h02); push(8'h11);
      wait_drain(ok);
      frm_ack = 1'b1;
      repeat (2) @(negedge clk);
      frm_ack = 1'b0;
      push(8'h22); push(8'h31);
      wait_valid(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ackout_valid got %b want 1", ok); end
      checks++; if (frm_len !== 5'd2) begin errors++; $display("FAIL ackout_len got %0d want 2", frm_len); end
      read_byte(5'd1);
      checks++; if (frm_byte !== 8'h22) begin errors++; $display("FAIL ackout_byte1 got %h want 22", frm_byte); end
      @(negedge clk);
      do_ack();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int pb = pop_total;
      // 16-byte payload 01..10: XOR of 01..0F is 00, ^10 = 10, ^LEN 10 = 00
      push(8'hA5); push(8'h10);
      for (int i = 1; i <= 16; i++) push(8'(i));
      push(8'h00);
      push(8'hA5); push(8'h01); push(8'hFF); push(8'hFE);
      wait_valid(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", ok); end
      checks++; if (fv_cyc - pop_cycs[pb] != 18) begin errors++; $display("FAIL b2b_rate got %0d want 18", fv_cyc - pop_cycs[pb]); end
      checks++; if (frm_len !== 5'd16) begin errors++; $display("FAIL b2b_len got %0d want 16", frm_len); end
      read_byte(5'd15);
      checks++; if (frm_byte !== 8'h10) begin errors++; $display("FAIL b2b_byte15 got %h want 10", frm_byte); end
      read_byte(5'd16);
      checks++; if (frm_byte !== 8'h00) begin errors++; $display("FAIL b2b_byte16 got %h want 00", frm_byte); end
      @(negedge clk);
      do_ack();
      wait_valid(ok);
      checks++; if (frm_len !== 5'd1) begin errors++; $display("FAIL b2b_next_len got %0d want 1", frm_len); end
      read_byte(5'd0);
      checks++; if (frm_byte !== 8'hFF) begin errors++; $display("FAIL b2b_next_byte0 got %h want ff", frm_byte); end
      @(negedge clk);
      do_ack();
   endtask

   task automatic test_reset_mid();
      bit ok;
      int cb, lb;
      push(8'hA5); push(8'h04); push(8'h01); push(8'h02);
      wait_drain(ok);
      cb = chk_cnt;
      lb = len_cnt;
      rst = 1'b0;
      push(8'hA5); push(8'h01); push(8'h7E); push(8'h7F);
      @(negedge clk);
      #1;
      checks++; if (rd_uart !== 1'b0)   begin errors++; $display("FAIL rmid_rd_uart got %b want 0", rd_uart); end
      checks++; if (frm_len !== 5'd0)   begin errors++; $display("FAIL rmid_len got %0d want 0", frm_len); end
      checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rmid_drop got %h want 00", drop_cnt); end
      checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", frm_valid); end
      rst = 1'b1;
      wait_valid(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_after_valid got %b want 1", ok); end
      checks++; if (frm_len !== 5'd1) begin errors++; $display("FAIL rmid_after_len got %0d want 1", frm_len); end
      read_byte(5'd0);
      checks++; if (frm_byte !== 8'h7E) begin errors++; $display("FAIL rmid_after_byte got %h want 7e", frm_byte); end
      checks++; if ((chk_cnt - cb) + (len_cnt - lb) != 0) begin errors++; $display("FAIL rmid_err_pulses got %0d want 0", (chk_cnt - cb) + (len_cnt - lb)); end
      @(negedge clk);
      do_ack();
   endtask

   task automatic test_timeout();
      bit ok;
      int cb = chk_cnt;
      int lb = len_cnt;
      push(8'hA5); push(8'h02); push(8'h01);
      wait_drain(ok);
`ifdef UART_FRAME_TIMEOUT_EN
      repeat (80) @(negedge clk);
      checks++; if (chk_cnt - cb != 0) begin errors++; $display("FAIL tmo_early got %0d want 0", chk_cnt - cb); end
      repeat (40) @(negedge clk);
      checks++; if (chk_cnt - cb != 1) begin errors++; $display("FAIL tmo_chk_pulses got %0d want 1", chk_cnt - cb); end
      checks++; if (len_cnt - lb != 0) begin errors++; $display("FAIL tmo_len_pulses got %0d want 0", len_cnt - lb); end
      push(8'hA5); push(8'h01); push(8'h33); push(8'h32);
      wait_valid(ok);
      checks++; if (frm_len !== 5'd1) begin errors++; $display("FAIL tmo_next_len got %0d want 1", frm_len); end
`else
      repeat (200) @(negedge clk);
      checks++; if ((chk_cnt - cb) + (len_cnt - lb) != 0) begin errors++; $display("FAIL notmo_pulses got %0d want 0", (chk_cnt - cb) + (len_cnt - lb)); end
      checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL notmo_valid got %b want 0", frm_valid); end
      // Frame still in DATA: finish it (02 ^ 01 ^ 02 = 01)
      push(8'h02); push(8'h01);
      wait_valid(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL notmo_resume got %b want 1", ok); end
      checks++; if (frm_len !== 5'd2) begin errors++; $display("FAIL notmo_len got %0d want 2", frm_len); end
`endif
      @(negedge clk);
      do_ack();
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_chk_err();
      test_len_err_drop();
      test_hold_backpressure();
      test_ack_outside_hold();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
